// File: rtl/controle_pkg.sv
// Shared definitions for the multicycle control unit: opcode map, state
// encoding, PC-source and ALU-operation codes, and the control word layout.
package controle_pkg;

   // Opcode map (0000..1000 are register ALU operations)
   localparam logic [3:0] OP_ULA_MAX  = 4'b1000;
   localparam logic [3:0] OP_CARGA    = 4'b1001;
   localparam logic [3:0] OP_ARMAZENA = 4'b1010;
   localparam logic [3:0] OP_SALTO    = 4'b1011;
   localparam logic [3:0] OP_DESVIO   = 4'b1100;
   localparam logic [3:0] OP_ADDI     = 4'b1101;
   localparam logic [3:0] OP_ILEGAL   = 4'b1110;
   localparam logic [3:0] OP_NOP      = 4'b1111;

   // State encoding, visible on ESTADO for debug
   typedef enum logic [2:0] {
      ST_BUSCA   = 3'd0,
      ST_DECOD   = 3'd1,
      ST_EXEC    = 3'd2,
      ST_MEM     = 3'd3,
      ST_ESCRITA = 3'd4,
      ST_ERRO    = 3'd5
   } estado_t;

   // PC source select
   localparam logic [1:0] FCP_PC_MAIS_1 = 2'b00;
   localparam logic [1:0] FCP_DESVIO    = 2'b01;
   localparam logic [1:0] FCP_SALTO     = 2'b10;

   // ALU operation select
   localparam logic [1:0] ULA_SOMA  = 2'b00;
   localparam logic [1:0] ULA_SUB   = 2'b01;
   localparam logic [1:0] ULA_CODOP = 2'b10;

   // Control word driven towards the datapath
   typedef struct packed {
      logic       escpc;
      logic [1:0] fontecp;
      logic       escir;
      logic       lermem;
      logic       escmem;
      logic       ioud;
      logic [1:0] ulaop;
      logic       ulafonteb;
      logic       memparareg;
      logic       escreg;
      logic       erro;
   } ctrl_t;

   // True for the register-register ALU opcodes
   function automatic logic op_ula(input logic [3:0] codop);
      return (codop <= OP_ULA_MAX);
   endfunction

endpackage

// File: rtl/temporizador_mem.sv
// Memory wait watchdog: counts stalled cycles in a wait state.
// Ports: CLK, RST_N (async, active-low); limpa clears the count,
// incrementa advances it; estouro is high while the count equals LIMITE.
module temporizador_mem #(
   parameter int unsigned LIMITE = 8
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic limpa,
   input  logic incrementa,
   output logic estouro
);

   localparam int unsigned LARGURA = (LIMITE < 1) ? 1 : $clog2(LIMITE + 1);

   logic [LARGURA-1:0] contagem;

   // Saturates at LIMITE; the FSM leaves the wait state before it could wrap
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         contagem <= '0;
      end else if (limpa) begin
         contagem <= '0;
      end else if (incrementa && !estouro) begin
         contagem <= contagem + LARGURA'(1);
      end
   end

   assign estouro = (contagem == LARGURA'(LIMITE));

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control unit: sequences each instruction through fetch, decode,
// execute, memory and write-back, with a memory-wait watchdog that parks the
// block in a sticky error state.
// Ports: CLK, RST_N (async, active-low); CODOP opcode, ZERO ALU flag,
// MEM_PRONTO memory ready; ESCPC/FONTECP PC control, ESCIR IR load,
// LERMEM/ESCMEM/IOUD memory control, ULAOP/ULAFONTEB ALU control,
// MEMPARAREG/ESCREG register write-back, ESTADO debug state, ERRO error flag.
module controle_multiciclo
   import controle_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 8
) (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic [3:0] CODOP,
   input  logic       ZERO,
   input  logic       MEM_PRONTO,
   output logic       ESCPC,
   output logic [1:0] FONTECP,
   output logic       ESCIR,
   output logic       LERMEM,
   output logic       ESCMEM,
   output logic       IOUD,
   output logic [1:0] ULAOP,
   output logic       ULAFONTEB,
   output logic       MEMPARAREG,
   output logic       ESCREG,
   output logic [2:0] ESTADO,
   output logic       ERRO
);

   estado_t estado;
   estado_t prox_estado;
   ctrl_t   ctrl;
   logic    limpa;
   logic    incrementa;
   logic    estouro;

   temporizador_mem #(
      .LIMITE(MEM_TIMEOUT)
   ) u_temporizador (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .limpa     (limpa),
      .incrementa(incrementa),
      .estouro   (estouro)
   );

   // State register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         estado <= ST_BUSCA;
      end else begin
         estado <= prox_estado;
      end
   end

   // Next-state and output decode
   always_comb begin
      prox_estado = estado;
      ctrl        = '0;

      case (estado)
         ST_BUSCA: begin
            ctrl.lermem = 1'b1;
            if (MEM_PRONTO) begin
               ctrl.escir   = 1'b1;
               ctrl.escpc   = 1'b1;
               ctrl.fontecp = FCP_PC_MAIS_1;
               prox_estado  = ST_DECOD;
            end else if (estouro) begin
               prox_estado = ST_ERRO;
            end
         end

         ST_DECOD: begin
            case (CODOP)
               OP_SALTO: begin
                  ctrl.escpc   = 1'b1;
                  ctrl.fontecp = FCP_SALTO;
                  prox_estado  = ST_BUSCA;
               end
               OP_NOP:    prox_estado = ST_BUSCA;
               OP_ILEGAL: prox_estado = ST_ERRO;
               default:   prox_estado = ST_EXEC;
            endcase
         end

         ST_EXEC: begin
            if (op_ula(CODOP)) begin
               ctrl.ulaop  = ULA_CODOP;
               prox_estado = ST_ESCRITA;
            end else if (CODOP == OP_ADDI) begin
               ctrl.ulafonteb = 1'b1;
               ctrl.ulaop     = ULA_SOMA;
               prox_estado    = ST_ESCRITA;
            end else if (CODOP == OP_CARGA || CODOP == OP_ARMAZENA) begin
               ctrl.ulafonteb = 1'b1;
               ctrl.ulaop     = ULA_SOMA;
               prox_estado    = ST_MEM;
            end else if (CODOP == OP_DESVIO) begin
               ctrl.ulaop   = ULA_SUB;
               ctrl.fontecp = FCP_DESVIO;
               ctrl.escpc   = ZERO;
               prox_estado  = ST_BUSCA;
            end else begin
               // Jump/nop/illegal never reach EXEC; recover to fetch
               prox_estado = ST_BUSCA;
            end
         end

         ST_MEM: begin
            ctrl.ioud   = 1'b1;
            ctrl.lermem = (CODOP == OP_CARGA);
            ctrl.escmem = (CODOP == OP_ARMAZENA);
            if (MEM_PRONTO) begin
               prox_estado = (CODOP == OP_CARGA) ? ST_ESCRITA : ST_BUSCA;
            end else if (estouro) begin
               prox_estado = ST_ERRO;
            end
         end

         ST_ESCRITA: begin
            ctrl.escreg     = 1'b1;
            ctrl.memparareg = (CODOP == OP_CARGA);
            prox_estado     = ST_BUSCA;
         end

         ST_ERRO: begin
            ctrl.erro   = 1'b1;
            prox_estado = ST_ERRO;
         end

         default: prox_estado = ST_ERRO;
      endcase

      // Watchdog: restart on any state change, count stalled wait cycles
      limpa      = (prox_estado != estado);
      incrementa = ((estado == ST_BUSCA) || (estado == ST_MEM)) && !MEM_PRONTO;
   end

   // Reset forces every output low immediately, aborting any partial write
   assign ESCPC      = RST_N & ctrl.escpc;
   assign FONTECP    = RST_N ? ctrl.fontecp : 2'b00;
   assign ESCIR      = RST_N & ctrl.escir;
   assign LERMEM     = RST_N & ctrl.lermem;
   assign ESCMEM     = RST_N & ctrl.escmem;
   assign IOUD       = RST_N & ctrl.ioud;
   assign ULAOP      = RST_N ? ctrl.ulaop : 2'b00;
   assign ULAFONTEB  = RST_N & ctrl.ulafonteb;
   assign MEMPARAREG = RST_N & ctrl.memparareg;
   assign ESCREG     = RST_N & ctrl.escreg;
   assign ESTADO     = RST_N ? 3'(estado) : 3'd0;
   assign ERRO       = RST_N & ctrl.erro;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Bench for controle_multiciclo: per-cycle stimulus and expected control
// words are queued, then driven and compared cycle by cycle.
module tb_controle_multiciclo;
   import controle_pkg::*;

   localparam int unsigned TIMEOUT = 8;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic [3:0] CODOP = 4'b1111;
   logic       ZERO = 1'b0;
   logic       MEM_PRONTO = 1'b0;
   logic       ESCPC;
   logic [1:0] FONTECP;
   logic       ESCIR;
   logic       LERMEM;
   logic       ESCMEM;
   logic       IOUD;
   logic [1:0] ULAOP;
   logic       ULAFONTEB;
   logic       MEMPARAREG;
   logic       ESCREG;
   logic [2:0] ESTADO;
   logic       ERRO;

   int erros  = 0;
   int checks = 0;

   typedef struct packed {
      logic [3:0] op;
      logic       z;
      logic       pr;
   } stim_t;

   stim_t       q_stim[$];
   logic [16:0] q_esp[$];

   controle_multiciclo #(.MEM_TIMEOUT(TIMEOUT)) dut (
      .CLK       (CLK),
      .RST_N     (RST_N),
      .CODOP     (CODOP),
      .ZERO      (ZERO),
      .MEM_PRONTO(MEM_PRONTO),
      .ESCPC     (ESCPC),
      .FONTECP   (FONTECP),
      .ESCIR     (ESCIR),
      .LERMEM    (LERMEM),
      .ESCMEM    (ESCMEM),
      .IOUD      (IOUD),
      .ULAOP     (ULAOP),
      .ULAFONTEB (ULAFONTEB),
      .MEMPARAREG(MEMPARAREG),
      .ESCREG    (ESCREG),
      .ESTADO    (ESTADO),
      .ERRO      (ERRO)
   );

   always #5 CLK = ~CLK;

   // Observed control word: escpc fontecp escir lermem escmem ioud ulaop ulafb mpr escreg estado erro
   function automatic logic [16:0] saida();
      return {ESCPC, FONTECP, ESCIR, LERMEM, ESCMEM, IOUD, ULAOP,
              ULAFONTEB, MEMPARAREG, ESCREG, ESTADO, ERRO};
   endfunction

   function automatic logic [16:0] pk(input logic escpc, input logic [1:0] fcp,
                                      input logic escir, input logic lermem,
                                      input logic escmem, input logic ioud,
                                      input logic [1:0] ulaop, input logic ulafb,
                                      input logic mpr, input logic escreg,
                                      input logic [2:0] est, input logic erro);
      return {escpc, fcp, escir, lermem, escmem, ioud, ulaop, ulafb, mpr, escreg, est, erro};
   endfunction

   function automatic logic [16:0] v_busca_esp();   return pk(0,2'b00,0,1,0,0,2'b00,0,0,0,3'd0,0); endfunction
   function automatic logic [16:0] v_busca_ace();   return pk(1,2'b00,1,1,0,0,2'b00,0,0,0,3'd0,0); endfunction
   function automatic logic [16:0] v_decod();       return pk(0,2'b00,0,0,0,0,2'b00,0,0,0,3'd1,0); endfunction
   function automatic logic [16:0] v_decod_salto(); return pk(1,2'b10,0,0,0,0,2'b00,0,0,0,3'd1,0); endfunction
   function automatic logic [16:0] v_exec_ula();    return pk(0,2'b00,0,0,0,0,2'b10,0,0,0,3'd2,0); endfunction
   function automatic logic [16:0] v_exec_imed();   return pk(0,2'b00,0,0,0,0,2'b00,1,0,0,3'd2,0); endfunction
   function automatic logic [16:0] v_exec_desvio(input logic z); return pk(z,2'b01,0,0,0,0,2'b01,0,0,0,3'd2,0); endfunction
   function automatic logic [16:0] v_mem_ld();      return pk(0,2'b00,0,1,0,1,2'b00,0,0,0,3'd3,0); endfunction
   function automatic logic [16:0] v_mem_st();      return pk(0,2'b00,0,0,1,1,2'b00,0,0,0,3'd3,0); endfunction
   function automatic logic [16:0] v_escrita(input logic ld); return pk(0,2'b00,0,0,0,0,2'b00,0,ld,1,3'd4,0); endfunction
   function automatic logic [16:0] v_erro();        return pk(0,2'b00,0,0,0,0,2'b00,0,0,0,3'd5,1); endfunction

   task automatic empilha(input logic [3:0] op, input logic z, input logic pr, input logic [16:0] esp);
      q_stim.push_back('{op: op, z: z, pr: pr});
      q_esp.push_back(esp);
   endtask

   // Drives one queued cycle (caller is just after a falling edge) and returns observed/expected
   task automatic passo(output logic [16:0] obs, output logic [16:0] esp);
      stim_t s;
      s = q_stim.pop_front();
      CODOP = s.op; ZERO = s.z; MEM_PRONTO = s.pr;
      #1;
      obs = saida();
      esp = q_esp.pop_front();
      @(negedge CLK);
   endtask

   task automatic pulso_reset();
      RST_N = 1'b0; MEM_PRONTO = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
   endtask

   task automatic test_reset();
      logic [16:0] o, e;
      int n = 0;
      RST_N = 1'b0; CODOP = OP_NOP; ZERO = 1'b0; MEM_PRONTO = 1'b1;
      #1;
      checks++;
      if (saida() !== 17'd0) begin
         erros++;
         $display("FAIL test_reset em_reset: obtido=%b esperado=%b", saida(), 17'd0);
      end
      @(negedge CLK);
      RST_N = 1'b1;
      empilha(OP_NOP, 0, 1, v_busca_ace());
      empilha(OP_NOP, 0, 0, v_decod());
      empilha(OP_NOP, 0, 0, v_busca_esp());
      while (q_esp.size() > 0) begin
         passo(o, e); n++; checks++;
         if (o !== e) begin
            erros++;
            $display("FAIL test_reset ciclo %0d: obtido=%b esperado=%b", n, o, e);
         end
      end
   endtask

   task automatic test_ula();
      logic [16:0] o, e;
      int n = 0;
      empilha(4'b0011, 0, 1, v_busca_ace());
      empilha(4'b0011, 1, 1, v_decod());
      empilha(4'b0011, 0, 1, v_exec_ula());
      empilha(4'b0011, 1, 1, v_escrita(0));
      empilha(4'b0011, 0, 0, v_busca_esp());
      while (q_esp.size() > 0) begin
         passo(o, e); n++; checks++;
         if (o !== e) begin
            erros++;
            $display("FAIL test_ula ciclo %0d: obtido=%b esperado=%b", n, o, e);
         end
      end
   endtask

   task automatic test_carga_espera();
      logic [16:0] o, e;
      int n = 0;
      empilha(OP_CARGA, 0, 1, v_busca_ace());
      empilha(OP_CARGA, 0, 0, v_decod());
      empilha(OP_CARGA, 0, 0, v_exec_imed());
      for (int i = 0; i < 3; i++) empilha(OP_CARGA, 0, 0, v_mem_ld());
      empilha(OP_CARGA, 0, 1, v_mem_ld());
      empilha(OP_CARGA, 0, 0, v_escrita(1));
      empilha(OP_CARGA, 0, 0, v_busca_esp());
      while (q_esp.size() > 0) begin
         passo(o, e); n++; checks++;
         if (o !== e) begin
            erros++;
            $display("FAIL test_carga_espera ciclo %0d: obtido=%b esperado=%b", n, o, e);
         end
      end
   endtask

   task automatic test_armazena();
      logic [16:0] o, e;
      int n = 0;
      empilha(OP_ARMAZENA, 0, 1, v_busca_ace());
      empilha(OP_ARMAZENA, 0, 1, v_decod());
      empilha(OP_ARMAZENA, 0, 1, v_exec_imed());
      empilha(OP_ARMAZENA, 0, 1, v_mem_st());
      empilha(OP_ARMAZENA, 0, 0, v_busca_esp());
      while (q_esp.size() > 0) begin
         passo(o, e); n++; checks++;
         if (o !== e) begin
            erros++;
            $display("FAIL test_armazena ciclo %0d: obtido=%b esperado=%b", n, o, e);
         end
      end
   endtask

   task automatic test_desvio();
      logic [16:0] o, e;
      int n = 0;
      empilha(OP_DESVIO, 1, 1, v_busca_ace());
      empilha(OP_DESVIO, 1, 1, v_decod());
      empilha(OP_DESVIO, 1, 1, v_exec_desvio(1));
      empilha(OP_DESVIO, 0, 1, v_busca_ace());
      empilha(OP_DESVIO, 0, 1, v_decod());
      empilha(OP_DESVIO, 0, 1, v_exec_desvio(0));
      empilha(OP_DESVIO, 0, 0, v_busca_esp());
      while (q_esp.size() > 0) begin
         passo(o, e); n++; checks++;
         if (o !== e) begin
            erros++;
            $display("FAIL test_desvio ciclo %0d: obtido=%b esperado=%b", n, o, e);
         end
      end
   endtask

   task automatic test_salto_nop_addi();
      logic [16:0] o, e;
      int n = 0;
      empilha(OP_SALTO, 0, 1, v_busca_ace());
      empilha(OP_SALTO, 0, 1, v_decod_salto());
      empilha(OP_NOP,   1, 1, v_busca_ace());
      empilha(OP_NOP,   1, 1, v_decod());
      empilha(OP_ADDI,  0, 1, v_busca_ace());
      empilha(OP_ADDI,  0, 1, v_decod());
      empilha(OP_ADDI,  0, 1, v_exec_imed());
      empilha(OP_ADDI,  0, 1, v_escrita(0));
      empilha(OP_ADDI,  0, 0, v_busca_esp());
      while (q_esp.size() > 0) begin
         passo(o, e); n++; checks++;
         if (o !== e) begin
            erros++;
            $display("FAIL test_salto_nop_addi ciclo %0d: obtido=%b esperado=%b", n, o, e);
         end
      end
   endtask

   task automatic test_timeout();
      logic [16:0] o, e;
      int n = 0;
      pulso_reset();
      // Ready in the 9th fetch cycle is still accepted
      for (int i = 0; i < 8; i++) empilha(OP_NOP, 0, 0, v_busca_esp());
      empilha(OP_NOP, 0, 1, v_busca_ace());
      empilha(OP_NOP, 0, 0, v_decod());
      // Load stalled 9 cycles in MEM times out
      empilha(OP_CARGA, 0, 1, v_busca_ace());
      empilha(OP_CARGA, 0, 0, v_decod());
      empilha(OP_CARGA, 0, 0, v_exec_imed());
      for (int i = 0; i < 9; i++) empilha(OP_CARGA, 0, 0, v_mem_ld());
      empilha(OP_CARGA, 0, 1, v_erro());
      while (q_esp.size() > 0) begin
         passo(o, e); n++; checks++;
         if (o !== e) begin
            erros++;
            $display("FAIL test_timeout_mem ciclo %0d: obtido=%b esperado=%b", n, o, e);
         end
      end
      // Fetch withheld 9 cycles times out
      pulso_reset();
      n = 0;
      for (int i = 0; i < 9; i++) empilha(OP_NOP, 0, 0, v_busca_esp());
      empilha(OP_NOP, 0, 1, v_erro());
      while (q_esp.size() > 0) begin
         passo(o, e); n++; checks++;
         if (o !== e) begin
            erros++;
            $display("FAIL test_timeout_busca ciclo %0d: obtido=%b esperado=%b", n, o, e);
         end
      end
   endtask

   task automatic test_ilegal();
      logic [16:0] o, e;
      int n = 0;
      pulso_reset();
      empilha(OP_ILEGAL, 0, 1, v_busca_ace());
      empilha(OP_ILEGAL, 0, 0, v_decod());
      for (int i = 0; i < 20; i++)
         empilha(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), v_erro());
      while (q_esp.size() > 0) begin
         passo(o, e); n++; checks++;
         if (o !== e) begin
            erros++;
            $display("FAIL test_ilegal ciclo %0d: obtido=%b esperado=%b", n, o, e);
         end
      end
      RST_N = 1'b0;
      #1;
      checks++;
      if (saida() !== 17'd0) begin
         erros++;
         $display("FAIL test_ilegal reset: obtido=%b esperado=%b", saida(), 17'd0);
      end
      @(negedge CLK);
      RST_N = 1'b1; MEM_PRONTO = 1'b0;
      #1;
      checks++;
      if (saida() !== v_busca_esp()) begin
         erros++;
         $display("FAIL test_ilegal pos_reset: obtido=%b esperado=%b", saida(), v_busca_esp());
      end
      @(negedge CLK);
   endtask

   task automatic test_reset_assincrono();
      logic [16:0] o, e;
      int n = 0;
      empilha(OP_ARMAZENA, 0, 1, v_busca_ace());
      empilha(OP_ARMAZENA, 0, 0, v_decod());
      empilha(OP_ARMAZENA, 0, 0, v_exec_imed());
      empilha(OP_ARMAZENA, 0, 0, v_mem_st());
      while (q_esp.size() > 1) begin
         passo(o, e); n++; checks++;
         if (o !== e) begin
            erros++;
            $display("FAIL test_reset_assincrono ciclo %0d: obtido=%b esperado=%b", n, o, e);
         end
      end
      // Stay in MEM, then drop reset between edges
      CODOP = OP_ARMAZENA; ZERO = 1'b0; MEM_PRONTO = 1'b0;
      #1;
      e = q_esp.pop_front();
      void'(q_stim.pop_front());
      checks++;
      if (saida() !== e) begin
         erros++;
         $display("FAIL test_reset_assincrono mem: obtido=%b esperado=%b", saida(), e);
      end
      #2;
      RST_N = 1'b0;
      #1;
      checks++;
      if (saida() !== 17'd0) begin
         erros++;
         $display("FAIL test_reset_assincrono abortado: obtido=%b esperado=%b", saida(), 17'd0);
      end
      @(negedge CLK);
      RST_N = 1'b1;
      #1;
      checks++;
      if (saida() !== v_busca_esp()) begin
         erros++;
         $display("FAIL test_reset_assincrono liberado: obtido=%b esperado=%b", saida(), v_busca_esp());
      end
      @(negedge CLK);
   endtask

   initial begin
      @(negedge CLK);
      test_reset();
      test_ula();
      test_carga_espera();
      test_armazena();
      test_desvio();
      test_salto_nop_addi();
      test_timeout();
      test_ilegal();
      test_reset_assincrono();
      $display("Result: errors=%0d of %0d checks", erros, checks);
      $finish;
   end

endmodule

// File: doc/controle_multiciclo.md
# controle_multiciclo

Multicycle control unit for the 4-bit-opcode processor datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives the PC-source, register-write, memory and ALU selects, and handshakes with instruction/data memory through a ready signal. A wait-timeout watchdog moves the block to a sticky error state when memory stalls too long.

## Interface
- MEM_TIMEOUT, default 8: maximum number of extra wait cycles allowed in BUSCA or MEM before the block enters ERRO.
- CLK  in  1  clock; all state changes on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- CODOP  in  4  opcode from the IR; valid from DECOD onward.
- ZERO  in  1  ALU zero flag.
- MEM_PRONTO  in  1  memory ready/acknowledge for the current request.
- ESCPC  out  1  PC write enable.
- FONTECP  out  2  PC source: 00 = PC+1, 01 = branch target, 10 = jump target.
- ESCIR  out  1  IR load enable.
- LERMEM  out  1  memory read request.
- ESCMEM  out  1  memory write request.
- IOUD  out  1  memory address source: 0 = PC, 1 = ALU result.
- ULAOP  out  2  ALU operation: 00 = add, 01 = sub, 10 = by CODOP.
- ULAFONTEB  out  1  ALU B operand: 0 = register, 1 = immediate.
- MEMPARAREG  out  1  write-back source: 0 = ALU, 1 = memory.
- ESCREG  out  1  register file write enable.
- ESTADO  out  3  current state code, for debug.
- ERRO  out  1  sticky error flag.

## Operation
- **Opcode map:**
  - 0000–1000: ALU register operations.
  - 1001: load; 1010: store.
  - 1011: jump; 1100: branch if ZERO.
  - 1101: add-immediate.
  - 1110: illegal.
  - 1111: nop.
- **State codes:** BUSCA = 0, DECOD = 1, EXEC = 2, MEM = 3, ESCRITA = 4, ERRO = 5.
- **Output decode:** outputs are combinational from the state register, CODOP, ZERO and MEM_PRONTO. Any output not listed for a state is 0.
- **BUSCA:** LERMEM = 1, IOUD = 0.
  - When MEM_PRONTO = 1: ESCIR = 1, ESCPC = 1, FONTECP = 00, next state DECOD.
- **DECOD:**
  - 1011: ESCPC = 1, FONTECP = 10, next state BUSCA.
  - 1111: next state BUSCA, no enables.
  - 1110: next state ERRO.
  - All other opcodes: next state EXEC.
- **EXEC:**
  - ALU operations: ULAOP = 10, next state ESCRITA.
  - 1101: ULAFONTEB = 1, ULAOP = 00, next state ESCRITA.
  - Load/store: ULAFONTEB = 1, ULAOP = 00, next state MEM.
  - Branch: ULAOP = 01, FONTECP = 01, ESCPC = ZERO, next state BUSCA.
- **MEM:** IOUD = 1, LERMEM = 1 for load, ESCMEM = 1 for store; held until MEM_PRONTO = 1.
  - On ready: store goes to BUSCA, load goes to ESCRITA.
- **ESCRITA:** ESCREG = 1; MEMPARAREG = 1 only for load; next state BUSCA.
- **ERRO:**
  - All enables are 0; ERRO = 1.
  - The state is held until reset, regardless of inputs.
- **Watchdog:**
  - A wait counter of width $clog2(MEM_TIMEOUT+1) clears on every entry to BUSCA or MEM and increments each cycle MEM_PRONTO = 0.
  - If MEM_PRONTO = 0 while the counter equals MEM_TIMEOUT, the next state is ERRO.
  - MEM_PRONTO = 1 in the same cycle always wins over the timeout.
- **Reset (RST_N low):**
  - State = BUSCA, counter = 0, ERRO = 0.
  - All outputs are forced to 0, including LERMEM and ESTADO.
  - Reset asserted mid-instruction aborts it immediately, with no partial write enables.

## Timing
- Cycles per instruction with zero-wait memory (MEM_PRONTO = 1 in the first cycle of each access):
  - ALU / add-immediate: 4.
  - Load: 5.
  - Store: 4.
  - Branch: 3.
  - Jump / nop: 2.
- Each memory wait cycle adds 1.
- A request may be accepted in any of the first MEM_TIMEOUT+1 cycles of a wait state. Otherwise ERRO is entered on the next edge.
- Write enables (ESCPC, ESCIR, ESCREG, ESCMEM) are sampled by the datapath on the edge that ends the cycle in which they are high.
- After RST_N deassertion, LERMEM = 1 in the first cycle and the first accept is possible on the first edge.

## Structure
- **Shared package `controle_pkg`:**
  - Opcode constants.
  - State encoding (3-bit enum).
  - FONTECP codes and ULAOP codes.
- **Sub-module `temporizador_mem`:**
  - Parameterized wait counter with clear and increment inputs and an `estouro` output.
  - The FSM and output decode remain in `controle_multiciclo`.

## Test plan
- **ALU op:** reset, then CODOP = 0011 with MEM_PRONTO tied 1 → ESTADO sequence 0,1,2,4,0; ESCREG = 1 only in state 4; ULAOP = 10 in state 2.
- **Load with wait:** CODOP = 1001, MEM_PRONTO low for 3 cycles in MEM → LERMEM and IOUD = 1 held for 4 cycles, then ESCREG = 1 and MEMPARAREG = 1; 8 cycles total.
- **Branch:**
  - CODOP = 1100 with ZERO = 1 → ESCPC = 1 and FONTECP = 01 in EXEC.
  - With ZERO = 0 → ESCPC = 0.
  - Both cases return to BUSCA after 3 cycles.
- **Jump, nop, illegal:**
  - 1011 → ESCPC = 1, FONTECP = 10 in DECOD.
  - 1111 → no enables.
  - 1110 → ERRO = 1 and ESTADO = 5, held for 20 cycles until RST_N pulse.
- **Timeout boundary:** MEM_TIMEOUT = 8.
  - Ready given in the 9th BUSCA cycle → accepted.
  - Ready withheld for 9 cycles → ERRO on the next edge.
- **Asynchronous reset mid-MEM store:** RST_N low between edges → all outputs 0 immediately, including ESCMEM; after release, ESTADO = 0 and LERMEM = 1.
